// File: rtl/whirlpool_wcipher_ctrl_if.sv
// Block and result handshake bundle for the Whirlpool W-cipher sequencer.
interface whirlpool_wcipher_ctrl_if;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   modport master (
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_valid
   );
endinterface

// File: rtl/whirlpool_wcipher_ctrl.sv
// Whirlpool W-cipher round sequencer: init load, NUM_ROUNDS rounds, result handshake.
// Define WHIRLPOOL_HALF_ROUND_EN for the shared-rho half-round variant (two phases per round).
module whirlpool_wcipher_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned RC_W       = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    abort_i,
   whirlpool_wcipher_ctrl_if.slave hs,
   output logic                    init_load_o,
   output logic                    key_round_en_o,
   output logic                    state_round_en_o,
   output logic [RC_W-1:0]         rc_index_o,
   output logic                    last_round_o,
   output logic                    busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_ROUND,
      ST_DONE
   } state_t;

   localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS);

   state_t          state_q;
   logic [RC_W-1:0] rc_q;
   logic [RC_W-1:0] rc_d;
   logic            in_ready_q;
   logic            init_load_q;
   logic            key_en_q;
   logic            state_en_q;
   logic            last_q;
   logic            busy_q;
   logic            out_valid_q;
`ifdef WHIRLPOOL_HALF_ROUND_EN
   logic            phase_q;
`endif

   assign rc_d = rc_q + RC_ONE;

   always_ff @(posedge clk_i) begin
      if (reset_i || abort_i) begin
         state_q     <= ST_IDLE;
         rc_q        <= '0;
         in_ready_q  <= 1'b1;
         init_load_q <= 1'b0;
         key_en_q    <= 1'b0;
         state_en_q  <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef WHIRLPOOL_HALF_ROUND_EN
         phase_q     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (hs.in_valid) begin
                  state_q     <= ST_INIT;
                  in_ready_q  <= 1'b0;
                  init_load_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            ST_INIT: begin
               state_q     <= ST_ROUND;
               init_load_q <= 1'b0;
               rc_q        <= RC_ONE;
               last_q      <= (RC_ONE == RC_LAST);
               key_en_q    <= 1'b1;
`ifdef WHIRLPOOL_HALF_ROUND_EN
               state_en_q  <= 1'b0;
               phase_q     <= 1'b0;
`else
               state_en_q  <= 1'b1;
`endif
            end
            ST_ROUND: begin
`ifdef WHIRLPOOL_HALF_ROUND_EN
               // Phase K -> phase S keeps rc_index; only the S phase closes a round.
               if (!phase_q) begin
                  phase_q    <= 1'b1;
                  key_en_q   <= 1'b0;
                  state_en_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
                  if (rc_q == RC_LAST) begin
                     state_q     <= ST_DONE;
                     rc_q        <= '0;
                     key_en_q    <= 1'b0;
                     state_en_q  <= 1'b0;
                     last_q      <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     rc_q       <= rc_d;
                     last_q     <= (rc_d == RC_LAST);
                     key_en_q   <= 1'b1;
                     state_en_q <= 1'b0;
                  end
               end
`else
               if (rc_q == RC_LAST) begin
                  state_q     <= ST_DONE;
                  rc_q        <= '0;
                  key_en_q    <= 1'b0;
                  state_en_q  <= 1'b0;
                  last_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  rc_q   <= rc_d;
                  last_q <= (rc_d == RC_LAST);
               end
`endif
            end
            ST_DONE: begin
               if (hs.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign hs.in_ready      = in_ready_q;
   assign hs.out_valid     = out_valid_q;
   assign init_load_o      = init_load_q;
   assign key_round_en_o   = key_en_q;
   assign state_round_en_o = state_en_q;
   assign rc_index_o       = rc_q;
   assign last_round_o     = last_q;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_whirlpool_wcipher_ctrl.sv
// Self-checking bench for whirlpool_wcipher_ctrl against a cycle-age reference model.
module tb_whirlpool_wcipher_ctrl;

   localparam int N    = 10;
   localparam int RCW  = 4;
`ifdef WHIRLPOOL_HALF_ROUND_EN
   localparam int P    = 2;
`else
   localparam int P    = 1;
`endif
   localparam int DONE_AGE = 2 + N * P;

   logic           clk = 1'b0;
   logic           reset;
   logic           abort;
   logic           init_load;
   logic           key_en;
   logic           state_en;
   logic [RCW-1:0] rc_index;
   logic           last_round;
   logic           busy;

   int errors = 0;
   int checks = 0;
   int age    = 0;   // 0: idle, otherwise cycles elapsed since the accepting edge

   whirlpool_wcipher_ctrl_if ifc ();

   whirlpool_wcipher_ctrl #(
      .NUM_ROUNDS (N),
      .RC_W       (RCW)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .abort_i          (abort),
      .hs               (ifc.slave),
      .init_load_o      (init_load),
      .key_round_en_o   (key_en),
      .state_round_en_o (state_en),
      .rc_index_o       (rc_index),
      .last_round_o     (last_round),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s age=%0d observed=%0h expected=%0h", tag, age, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit iv, input bit ab, input bit ordy);
      if (rst || ab)             age = 0;
      else if (age == 0)         age = iv ? 1 : 0;
      else if (age >= DONE_AGE)  age = ordy ? 0 : age;
      else                       age = age + 1;
   endtask

   task automatic check_all();
      bit rounding;
      int idx, ph;
      rounding = (age >= 2) && (age < DONE_AGE);
      idx      = rounding ? (age - 2) / P + 1 : 0;
      ph       = rounding ? (age - 2) % P : 0;
      check("in_ready",   32'(ifc.in_ready),  32'(age == 0));
      check("busy",       32'(busy),          32'(age != 0));
      check("init_load",  32'(init_load),     32'(age == 1));
      check("rc_index",   32'(rc_index),      32'(idx));
      check("key_en",     32'(key_en),        32'(rounding && ph == 0));
      check("state_en",   32'(state_en),      32'(rounding && (P == 1 || ph == 1)));
      check("last_round", 32'(last_round),    32'(rounding && idx == N));
      check("out_valid",  32'(ifc.out_valid), 32'(age >= DONE_AGE));
      check("en_excl",    32'(P == 2 && key_en && state_en), 32'(0));
   endtask

   task automatic step(input bit rst, input bit iv, input bit ab, input bit ordy);
      reset         = rst;
      ifc.in_valid  = iv;
      abort         = ab;
      ifc.out_ready = ordy;
      @(posedge clk);
      model_edge(rst, iv, ab, ordy);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; abort = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;

      // reset held two cycles
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // single block, then five cycles of backpressure, then release
      step(0, 1, 0, 0);
      for (int i = 0; i < DONE_AGE - 1; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // out_ready while idle is ignored; abort in idle swallows in_valid
      step(0, 0, 0, 1);
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);

      // abort when rc_index reaches 4, then a full new block
      step(0, 1, 0, 0);
      for (int i = 0; i < 1 + 3 * P; i++) step(0, 0, 0, 0);
      check("rc_at_abort", 32'(rc_index), 32'(4));
      step(0, 0, 1, 1);
      step(0, 1, 0, 0);
      for (int i = 0; i < DONE_AGE; i++) step(0, 0, 0, 0);
      step(0, 0, 0, 1);

      // in_valid held during the run must not restart it
      step(0, 1, 0, 0);
      for (int i = 0; i < DONE_AGE + 2; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 1);

      // reset mid-block behaves like abort
      step(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
